popcnt_accum_4to3: RTL and testbench

- Sequential popcount stage built around the 4-to-3 compressor.
- Accepts wide binary vectors over a valid/ready handshake, slices each into nibbles, and feeds LANES nibbles per cycle into LANES instances of adder_4to3.
- Accumulates the 3-bit compressor outputs across beats and across multi-vector packets, then presents the total downstream; this is the popcount/accumulate stage of the binary MAC path.

---
 rtl/popcnt_accum_4to3.sv | 161 ++++++++++++++++
 tb/tb_popcnt_accum_4to3.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_accum_4to3.sv
// Popcount/accumulate stage: nibble-wise 4-to-3 compression, packet accumulation.
// Optional BNN_XNOR_EN: XNOR of in_data with in_weight, plus signed out_dot result.

module adder_4to3 (
  input  logic [3:0] x,
  output logic       sum,
  output logic       carry,
  output logic       cout
);
  logic s1, s2, c1, c2, c3;

  // two half adders, then merge; c1 and c3 can never both be set
  always_comb begin
    s1    = x[0] ^ x[1];
    c1    = x[0] & x[1];
    s2    = x[2] ^ x[3];
    c2    = x[2] & x[3];
    c3    = s1 & s2;
    sum   = s1 ^ s2;
    carry = c1 ^ c2 ^ c3;
    cout  = (c1 & c2) | (c1 & c3) | (c2 & c3);
  end
endmodule

module popcnt_accum_4to3 #(
  parameter int DATA_W = 64,
  parameter int LANES  = 4,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
`ifdef BNN_XNOR_EN
  input  logic [DATA_W-1:0] in_weight,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_count,
  output logic              out_ovf,
`ifdef BNN_XNOR_EN
  output logic signed [ACC_W:0] out_dot,
`endif
  output logic              busy
);
  localparam int SLICE  = 4 * LANES;
  localparam int NBEATS = DATA_W / SLICE;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LSW    = $clog2(SLICE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] sr, cap;
  logic [BW-1:0]     beat;
  logic              last;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [LANES-1:0]  ls, lc, lco;
  logic [LSW-1:0]    lane_sum;
  logic [ACC_W:0]    acc_sum;
  logic [ACC_W-1:0]  acc_sat;
  logic              sat;
  logic              final_beat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    adder_4to3 u_add (
      .x     (sr[4*i +: 4]),
      .sum   (ls[i]),
      .carry (lc[i]),
      .cout  (lco[i])
    );
  end

`ifdef BNN_XNOR_EN
  logic [ACC_W-1:0] nvec;
  logic [ACC_W:0]   two_cnt, bits_in;
  assign cap     = ~(in_data ^ in_weight);
  assign two_cnt = {out_count, 1'b0};
  assign bits_in = (ACC_W+1)'(nvec) * (ACC_W+1)'(DATA_W);
  assign out_dot = $signed(two_cnt - bits_in);
`else
  assign cap = in_data;
`endif

  // decode lane values and add them, then saturate against the accumulator
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + LSW'({lco[i], lc[i], ls[i]});
    acc_sum = {1'b0, acc} + (ACC_W+1)'(lane_sum);
    sat     = acc_sum[ACC_W];
    acc_sat = sat ? '1 : acc_sum[ACC_W-1:0];
  end

  assign final_beat = (beat == BW'(NBEATS - 1));
  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE) && !rst;
  assign busy       = (state != IDLE);
  assign out_ovf    = ovf;

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = RUN;
      RUN:  if (final_beat) state_n = last ? DONE : IDLE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // datapath: capture, shift/accumulate, hold result until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      beat      <= '0;
      last      <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_count <= '0;
`ifdef BNN_XNOR_EN
      nvec      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sr   <= cap;
          last <= in_last;
          beat <= '0;
`ifdef BNN_XNOR_EN
          nvec <= nvec + 1'b1;
`endif
        end
        RUN: begin
          acc  <= acc_sat;
          ovf  <= ovf | sat;
          sr   <= sr >> SLICE;
          beat <= beat + 1'b1;
          if (final_beat && last) out_count <= acc_sat;
        end
        DONE: if (out_ready) begin
          acc  <= '0;
          ovf  <= 1'b0;
`ifdef BNN_XNOR_EN
          nvec <= '0;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_popcnt_accum_4to3.sv
// Directed bench for popcnt_accum_4to3 (ACC_W=16 and ACC_W=6 instances).
// Optional BNN_XNOR_EN checks of out_dot.

module tb_popcnt_accum_4to3;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready, sel6;
  logic [63:0] in_data, in_weight;
  logic        rdy16, ov16, ovf16, busy16;
  logic        rdy6, ov6, ovf6, busy6;
  logic [15:0] cnt16;
  logic [5:0]  cnt6;
  logic        rdy, ov, ovf, bsy;
  logic [31:0] cnt;
  logic        seen_ov;
  int          ntests = 0;
  int          nfail  = 0;
  int          lat;
`ifdef BNN_XNOR_EN
  logic signed [16:0] dot16;
  logic signed [6:0]  dot6;
`endif

  always #5 clk = ~clk;

  popcnt_accum_4to3 #(.DATA_W(64), .LANES(4), .ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & ~sel6),
    .in_ready  (rdy16),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef BNN_XNOR_EN
    .in_weight (in_weight),
    .out_dot   (dot16),
`endif
    .out_valid (ov16),
    .out_ready (sel6 ? 1'b1 : out_ready),
    .out_count (cnt16),
    .out_ovf   (ovf16),
    .busy      (busy16)
  );

  popcnt_accum_4to3 #(.DATA_W(64), .LANES(4), .ACC_W(6)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & sel6),
    .in_ready  (rdy6),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef BNN_XNOR_EN
    .in_weight (in_weight),
    .out_dot   (dot6),
`endif
    .out_valid (ov6),
    .out_ready (sel6 ? out_ready : 1'b1),
    .out_count (cnt6),
    .out_ovf   (ovf6),
    .busy      (busy6)
  );

  assign rdy = sel6 ? rdy6  : rdy16;
  assign ov  = sel6 ? ov6   : ov16;
  assign ovf = sel6 ? ovf6  : ovf16;
  assign bsy = sel6 ? busy6 : busy16;
  assign cnt = sel6 ? 32'(cnt6) : 32'(cnt16);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!rdy && n < 20) begin
      if (ov) seen_ov = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_last  = ~l;
  endtask

  task automatic wait_out(output int l);
    l = 1;
    while (!ov && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
    check("out_valid_seen", 32'(ov), 32'd1);
  endtask

  task automatic accept();
    @(posedge clk); #1;
    check("accept_drop", 32'(ov), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    sel6      = 1'b0;
    in_weight = '1;
    seen_ov   = 1'b0;

    @(posedge clk); #1;
    check("rst_in_ready", 32'(rdy), 32'd0);
    check("rst_valid", 32'(ov), 32'd0);
    check("rst_count", cnt, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(bsy), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(rdy), 32'd1);

    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("run_ready_low", 32'(rdy), 32'd0);
    check("run_busy", 32'(bsy), 32'd1);
    wait_out(lat);
    check("latency", 32'(lat), 32'd5);
    check("ones_count", cnt, 32'd64);
    check("ones_ovf", 32'(ovf), 32'd0);
    accept();
    check("idle_busy", 32'(bsy), 32'd0);
    check("idle_ready", 32'(rdy), 32'd1);

    send(64'h0000_0000_0000_000F, 1'b1);
    wait_out(lat);
    check("nib_count", cnt, 32'd4);
    accept();

    send(64'h8421_8421_8421_8421, 1'b1);
    wait_out(lat);
    check("8421_count", cnt, 32'd16);
    accept();

    seen_ov = 1'b0;
    send(64'hF0F0_F0F0_F0F0_F0F0, 1'b0);
    send(64'hF0F0_F0F0_F0F0_F0F0, 1'b0);
    send(64'hF0F0_F0F0_F0F0_F0F0, 1'b1);
    check("multi_no_early", 32'(seen_ov), 32'd0);
    wait_out(lat);
    check("multi_latency", 32'(lat), 32'd5);
    check("multi_count", cnt, 32'd96);
    accept();

    out_ready = 1'b0;
    send(64'h0000_0000_0000_000F, 1'b1);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 64'hFFFF_0000_FFFF_0000;
      in_last  = 1'b1;
      @(posedge clk); #1;
      check("stall_valid", 32'(ov), 32'd1);
      check("stall_count", cnt, 32'd4);
      check("stall_ready", 32'(rdy), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    accept();
    check("stall_idle", 32'(bsy), 32'd0);
    @(posedge clk); #1;
    check("stall_no_restart", 32'(bsy), 32'd0);

    sel6 = 1'b1;
    #1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_out(lat);
    check("sat_count", cnt, 32'd63);
    check("sat_ovf", 32'(ovf), 32'd1);
    accept();
    check("sat_ovf_clr", 32'(ovf), 32'd0);
    send(64'h0000_0000_0000_0001, 1'b1);
    wait_out(lat);
    check("post_sat_count", cnt, 32'd1);
    check("post_sat_ovf", 32'(ovf), 32'd0);
    accept();
    sel6 = 1'b0;
    #1;

    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 32'(bsy), 32'd0);
    check("midrst_valid", 32'(ov), 32'd0);
    check("midrst_ready", 32'(rdy), 32'd0);
    check("midrst_count", cnt, 32'd0);
    rst     = 1'b0;
    seen_ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov) seen_ov = 1'b1;
    end
    check("midrst_no_valid", 32'(seen_ov), 32'd0);
    send(64'h0000_0000_0000_0003, 1'b1);
    wait_out(lat);
    check("midrst_next_count", cnt, 32'd2);
    accept();

`ifdef BNN_XNOR_EN
    in_weight = '1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_out(lat);
    check("xnor_eq_count", cnt, 32'd64);
    check("xnor_eq_dot", 32'(dot16), 32'(64));
    accept();
    send(64'h0, 1'b1);
    wait_out(lat);
    check("xnor_ne_count", cnt, 32'd0);
    check("xnor_ne_dot", 32'(dot16), 32'(-64));
    accept();
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
